bram_port_arbiter: RTL and testbench
====================================

Name: bram_port_arbiter

Overview:
- Shares one single-port image BRAM (synchronous read, 1-cycle read latency) among three requesters:
  - cfg: JTAG-style config port. Writes or reads; highest priority.
  - ld: image loader. Sequential read bursts feeding the downscale engine.
  - st: result store. Writes downscaled pixels back.
- Sits between the memory instance and the control FSM / downscale datapath. It replaces the ad-hoc address muxing in the top level.

Parameters:
- ADDR_W, 16, BRAM address width
- DATA_W, 8, pixel width
- MAX_BURST, 16, maximum consecutive ld or st grants before yielding to the other burst requester (range 1..255)

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- cfg_req  in  1  cfg access request
- cfg_we  in  1  1 = write, 0 = read
- cfg_addr  in  ADDR_W  cfg address
- cfg_wdata  in  DATA_W  cfg write data
- cfg_gnt  out  1  cfg access accepted this cycle
- cfg_rvalid  out  1  cfg read data valid
- cfg_rdata  out  DATA_W  cfg read data
- ld_req  in  1  loader read request
- ld_addr  in  ADDR_W  loader read address
- ld_gnt  out  1  loader read accepted this cycle
- ld_rvalid  out  1  loader read data valid
- ld_rdata  out  DATA_W  loader read data
- st_req  in  1  store write request
- st_addr  in  ADDR_W  store address
- st_wdata  in  DATA_W  store data
- st_gnt  out  1  store write accepted this cycle
- mem_we  out  1  BRAM write enable
- mem_addr  out  ADDR_W  BRAM address
- mem_wdata  out  DATA_W  BRAM write data
- mem_rdata  in  DATA_W  BRAM read data (valid 1 cycle after address)
- owner  out  2  burst owner: 0 = none, 1 = ld, 2 = st

Behaviour:
- Reset (rst low, async):
  - All gnt and rvalid outputs = 0; mem_we = 0; mem_addr = 0; mem_wdata = 0; *_rdata = 0.
  - owner = 0; burst counter = 0; in-flight read tags cleared.
- Grants:
  - Combinational from the requests and registered state.
  - At most one gnt per cycle.
  - A request is accepted in a cycle only when its gnt is high in that cycle.
- Priority:
  - cfg_req always wins.
  - Otherwise the burst FSM chooses between ld and st.
- Burst FSM states: IDLE, LD_OWN, ST_OWN. owner output encodes the state.
  - IDLE:
    - ld_req wins if present, else st_req.
    - The winner's state is entered with count = 1.
  - LD_OWN:
    - Grant ld while ld_req = 1, unless count = MAX_BURST and st_req = 1.
    - In that case grant st, move to ST_OWN, count = 1.
    - If ld_req = 0: grant st if requesting (move to ST_OWN, count = 1), else go to IDLE, count = 0.
    - Count saturates at MAX_BURST when the other side is idle.
  - ST_OWN: symmetric to LD_OWN.
  - Cycles with a cfg grant leave the FSM state and count unchanged (the burst is frozen, not broken).
- Issue pipeline:
  - Cycle N: grant.
  - Cycle N+1: mem_addr, mem_we and mem_wdata are registered from the granted port.
  - With no grant in cycle N: mem_we = 0 at N+1, and mem_addr/mem_wdata hold their previous values.
- Read return:
  - A read granted at N has mem_rdata sampled at N+2.
  - At N+2 the matching rvalid pulses high for 1 cycle, and rdata is registered and held until the next rvalid.
  - A 2-stage tag pipeline (cfg-read / ld-read / none) routes the data.
  - Back-to-back reads give one rvalid per cycle, in order.
- Writes (cfg_we = 1, or st) never produce an rvalid.
- Read-after-write to the same address in consecutive grants returns the new data (the BRAM is write-first; the arbiter adds no bypass).
- Reset mid-operation drops in-flight reads: no rvalid after reset deassertion until new grants arrive.

Test Plan:
- Reset with all requests high: during reset all gnt = 0, mem_we = 0. Cycle 1 after release: cfg_gnt = 1 only, owner = 0.
- ld_req alone, addresses 0..5 on consecutive cycles, mem preloaded with data = addr+0x10 → ld_gnt each cycle. ld_rvalid from grant+2 with rdata 0x10..0x15 in order. owner = 1.
- MAX_BURST = 4, ld_req and st_req both continuously high → grant pattern ld×4, st×4, ld×4, … with owner toggling 1/2. st writes appear on mem_we one cycle after each st_gnt.
- cfg_req pulsed 1 cycle during the 3rd ld grant of a burst (MAX_BURST = 4) → that cycle cfg_gnt = 1, ld_gnt = 0. Burst resumes and ld still gets 4 total grants before st.
- cfg write 0xAB to addr 0x0040, then cfg read of 0x0040 on the next cycle → cfg_rvalid = 1 at read-grant+2, cfg_rdata = 0xAB. No ld_rvalid asserted.
- rst asserted 1 cycle after an ld read grant → no ld_rvalid ever appears for that read. owner = 0 after release.

Source files
------------

// File: rtl/bram_port_arbiter.sv
// bram_port_arbiter
// Shares one single-port, write-first image BRAM (1-cycle synchronous read)
// between the config port (cfg), the image loader (ld) and the result store
// (st). cfg always wins. ld and st take turns in bursts of at most MAX_BURST
// grants whenever both are waiting. Grants are combinational. The BRAM
// command is registered one cycle after the grant. Read data is routed back
// through a two-stage tag pipeline that is aligned with the BRAM latency.

module bram_port_arbiter #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 16   // legal range 1..255
) (
    input  logic              clk,
    input  logic              rst,        // asynchronous, active low

    input  logic              cfg_req,
    input  logic              cfg_we,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [DATA_W-1:0] cfg_wdata,
    output logic              cfg_gnt,
    output logic              cfg_rvalid,
    output logic [DATA_W-1:0] cfg_rdata,

    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    output logic              ld_gnt,
    output logic              ld_rvalid,
    output logic [DATA_W-1:0] ld_rdata,

    input  logic              st_req,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [DATA_W-1:0] st_wdata,
    output logic              st_gnt,

    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic [1:0]        owner
);

    // The encoding of this type is also the value driven on owner.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LD_OWN = 2'd1,
        ST_OWN = 2'd2
    } burst_state_t;

    // Identifies which requester a read in flight belongs to.
    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_CFG  = 2'd1,
        TAG_LD   = 2'd2
    } rd_tag_t;

    localparam logic [7:0] BURST_MAX = 8'(MAX_BURST);

    burst_state_t      state_q, state_d;
    logic [7:0]        count_q, count_d;
    logic              at_max;

    rd_tag_t           tag_s1_q;   // command is on the BRAM pins
    rd_tag_t           tag_s2_q;   // BRAM data is on mem_rdata
    logic [DATA_W-1:0] cfg_rdata_q;
    logic [DATA_W-1:0] ld_rdata_q;

    assign at_max = (count_q == BURST_MAX);

    // Pick this cycle's single winner and the burst state that follows from it.
    // NOTE: every output of this block gets a default first. Without the
    // defaults, a path that assigns nothing would infer a latch.
    always_comb begin
        cfg_gnt = 1'b0;
        ld_gnt  = 1'b0;
        st_gnt  = 1'b0;
        state_d = state_q;
        count_d = count_q;

        if (rst) begin
            if (cfg_req) begin
                // A cfg access freezes the burst. State and count are kept.
                cfg_gnt = 1'b1;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        if (ld_req) begin
                            ld_gnt  = 1'b1;
                            state_d = LD_OWN;
                            count_d = 8'd1;
                        end else if (st_req) begin
                            st_gnt  = 1'b1;
                            state_d = ST_OWN;
                            count_d = 8'd1;
                        end
                    end

                    LD_OWN: begin
                        if (ld_req && !(at_max && st_req)) begin
                            ld_gnt  = 1'b1;
                            count_d = at_max ? count_q : count_q + 8'd1;
                        end else if (st_req) begin
                            st_gnt  = 1'b1;
                            state_d = ST_OWN;
                            count_d = 8'd1;
                        end else begin
                            state_d = IDLE;
                            count_d = 8'd0;
                        end
                    end

                    ST_OWN: begin
                        if (st_req && !(at_max && ld_req)) begin
                            st_gnt  = 1'b1;
                            count_d = at_max ? count_q : count_q + 8'd1;
                        end else if (ld_req) begin
                            ld_gnt  = 1'b1;
                            state_d = LD_OWN;
                            count_d = 8'd1;
                        end else begin
                            state_d = IDLE;
                            count_d = 8'd0;
                        end
                    end

                    default: begin
                        state_d = IDLE;
                        count_d = 8'd0;
                    end
                endcase
            end
        end
    end

    // Burst owner register and grant counter.
    // NOTE: state registers are written with non-blocking assignments, so every
    // flop samples values from before the clock edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            count_q <= 8'd0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    assign owner = state_q;

    // Register the granted command onto the BRAM pins. Address and data hold
    // their values when there is no grant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_we <= 1'b0;
            if (cfg_gnt) begin
                mem_we    <= cfg_we;
                mem_addr  <= cfg_addr;
                mem_wdata <= cfg_wdata;
            end else if (ld_gnt) begin
                mem_addr  <= ld_addr;
            end else if (st_gnt) begin
                mem_we    <= 1'b1;
                mem_addr  <= st_addr;
                mem_wdata <= st_wdata;
            end
        end
    end

    // Track each read through the BRAM latency. Reset drops reads in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tag_s1_q <= TAG_NONE;
            tag_s2_q <= TAG_NONE;
        end else begin
            if (cfg_gnt && !cfg_we) begin
                tag_s1_q <= TAG_CFG;
            end else if (ld_gnt) begin
                tag_s1_q <= TAG_LD;
            end else begin
                tag_s1_q <= TAG_NONE;
            end
            tag_s2_q <= tag_s1_q;
        end
    end

    assign cfg_rvalid = (tag_s2_q == TAG_CFG);
    assign ld_rvalid  = (tag_s2_q == TAG_LD);

    // Capture returned data so that each rdata output holds until its next rvalid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cfg_rdata_q <= '0;
            ld_rdata_q  <= '0;
        end else begin
            if (cfg_rvalid) begin
                cfg_rdata_q <= mem_rdata;
            end
            if (ld_rvalid) begin
                ld_rdata_q <= mem_rdata;
            end
        end
    end

    // In the rvalid cycle the live BRAM word is forwarded. After that the
    // captured copy is held.
    assign cfg_rdata = cfg_rvalid ? mem_rdata : cfg_rdata_q;
    assign ld_rdata  = ld_rvalid  ? mem_rdata : ld_rdata_q;

    // Only one requester may own the BRAM in any cycle.
    a_one_grant : assert property (
        @(posedge clk) disable iff (!rst) $onehot0({cfg_gnt, ld_gnt, st_gnt})
    );

    // Only one read can be returning in any cycle.
    a_one_rvalid : assert property (
        @(posedge clk) disable iff (!rst) !(cfg_rvalid && ld_rvalid)
    );

endmodule

// File: tb/tb_bram_port_arbiter.sv
// tb_bram_port_arbiter
// Randomized and directed stimulus for bram_port_arbiter, which is paired with
// a behavioural write-first BRAM. A reference model predicts the grants, the
// BRAM command stream and the read data. The read data goes into per-port
// queues, and a monitor compares it whenever the DUT raises an rvalid.

module tb_bram_port_arbiter;

    localparam int ADDR_W    = 16;
    localparam int DATA_W    = 8;
    localparam int MAX_BURST = 4;

    logic              clk = 1'b0;
    logic              rst = 1'b1;

    logic              cfg_req = 1'b0;
    logic              cfg_we = 1'b0;
    logic [ADDR_W-1:0] cfg_addr = '0;
    logic [DATA_W-1:0] cfg_wdata = '0;
    logic              cfg_gnt;
    logic              cfg_rvalid;
    logic [DATA_W-1:0] cfg_rdata;

    logic              ld_req = 1'b0;
    logic [ADDR_W-1:0] ld_addr = '0;
    logic              ld_gnt;
    logic              ld_rvalid;
    logic [DATA_W-1:0] ld_rdata;

    logic              st_req = 1'b0;
    logic [ADDR_W-1:0] st_addr = '0;
    logic [DATA_W-1:0] st_wdata = '0;
    logic              st_gnt;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;
    logic [1:0]        owner;

    always #5 clk = ~clk;

    bram_port_arbiter #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .MAX_BURST(MAX_BURST)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_req   (cfg_req),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .cfg_gnt   (cfg_gnt),
        .cfg_rvalid(cfg_rvalid),
        .cfg_rdata (cfg_rdata),
        .ld_req    (ld_req),
        .ld_addr   (ld_addr),
        .ld_gnt    (ld_gnt),
        .ld_rvalid (ld_rvalid),
        .ld_rdata  (ld_rdata),
        .st_req    (st_req),
        .st_addr   (st_addr),
        .st_wdata  (st_wdata),
        .st_gnt    (st_gnt),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .owner     (owner)
    );

    // Behavioural single-port write-first BRAM
    logic [DATA_W-1:0] bram [0:65535];
    always @(posedge clk) begin
        if (mem_we) begin
            bram[mem_addr] <= mem_wdata;
            mem_rdata      <= mem_wdata;
        end else begin
            mem_rdata      <= bram[mem_addr];
        end
    end

    // Scoreboard state
    typedef struct {
        int               due;
        logic [DATA_W-1:0] data;
    } rd_exp_t;

    rd_exp_t           cfg_q[$];
    rd_exp_t           ld_q[$];
    int                checks   = 0;
    int                failures = 0;
    int                cyc      = 0;

    // Reference model state
    logic [DATA_W-1:0] shadow [0:65535];
    int                m_owner = 0;   // 0 none, 1 ld, 2 st
    int                m_run   = 0;   // grants used in the current burst
    logic              exp_we    = 1'b0;
    logic [ADDR_W-1:0] exp_addr  = '0;
    logic [DATA_W-1:0] exp_wdata = '0;
    logic [DATA_W-1:0] last_cfg  = '0;
    logic [DATA_W-1:0] last_ld   = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Burst arbitration at the level of the rules: returns 0 none, 1 ld, 2 st
    function automatic int pick_burst(int cur, int run, bit ld_r, bit st_r);
        bit mine;
        bit theirs;
        if (cur == 0) return ld_r ? 1 : (st_r ? 2 : 0);
        mine   = (cur == 1) ? ld_r : st_r;
        theirs = (cur == 1) ? st_r : ld_r;
        if (mine && !(run >= MAX_BURST && theirs)) return cur;
        if (theirs) return 3 - cur;
        return 0;
    endfunction

    // Monitor: compares outputs and advances the model in the middle of every cycle
    initial begin : monitor
        rd_exp_t    e;
        int         pick;
        logic [2:0] eg;
        forever begin
            @(negedge clk);
            cyc++;
            if (!rst) begin
                check("rst_gnt", 32'({cfg_gnt, ld_gnt, st_gnt}), 32'd0);
                check("rst_mem_we", 32'(mem_we), 32'd0);
                check("rst_mem_addr", 32'(mem_addr), 32'd0);
                check("rst_rvalid", 32'({cfg_rvalid, ld_rvalid}), 32'd0);
                check("rst_owner", 32'(owner), 32'd0);
                check("rst_rdata", 32'({cfg_rdata, ld_rdata}), 32'd0);
                m_owner   = 0;
                m_run     = 0;
                exp_we    = 1'b0;
                exp_addr  = '0;
                exp_wdata = '0;
                last_cfg  = '0;
                last_ld   = '0;
                cfg_q.delete();
                ld_q.delete();
            end else begin
                // BRAM command registered from last cycle's grant
                check("mem_we", 32'(mem_we), 32'(exp_we));
                check("mem_addr", 32'(mem_addr), 32'(exp_addr));
                check("mem_wdata", 32'(mem_wdata), 32'(exp_wdata));
                if (exp_we) shadow[exp_addr] = exp_wdata;

                // cfg read return
                if (cfg_rvalid) begin
                    if (cfg_q.size() == 0) begin
                        check("cfg_rvalid_unexpected", 32'(cfg_rvalid), 32'd0);
                    end else begin
                        e = cfg_q.pop_front();
                        check("cfg_rdata", 32'(cfg_rdata), 32'(e.data));
                        check("cfg_rvalid_cycle", 32'(cyc), 32'(e.due));
                        last_cfg = e.data;
                    end
                end else begin
                    if (cfg_q.size() > 0 && cfg_q[0].due <= cyc) begin
                        check("cfg_rvalid_missing", 32'(cfg_rvalid), 32'd1);
                        e = cfg_q.pop_front();
                    end
                    check("cfg_rdata_hold", 32'(cfg_rdata), 32'(last_cfg));
                end

                // ld read return
                if (ld_rvalid) begin
                    if (ld_q.size() == 0) begin
                        check("ld_rvalid_unexpected", 32'(ld_rvalid), 32'd0);
                    end else begin
                        e = ld_q.pop_front();
                        check("ld_rdata", 32'(ld_rdata), 32'(e.data));
                        check("ld_rvalid_cycle", 32'(cyc), 32'(e.due));
                        last_ld = e.data;
                    end
                end else begin
                    if (ld_q.size() > 0 && ld_q[0].due <= cyc) begin
                        check("ld_rvalid_missing", 32'(ld_rvalid), 32'd1);
                        e = ld_q.pop_front();
                    end
                    check("ld_rdata_hold", 32'(ld_rdata), 32'(last_ld));
                end

                // Arbitration
                check("owner", 32'(owner), 32'(m_owner));
                exp_we = 1'b0;
                if (cfg_req) begin
                    eg        = 3'b100;
                    exp_we    = cfg_we;
                    exp_addr  = cfg_addr;
                    exp_wdata = cfg_wdata;
                    if (!cfg_we) begin
                        e.due  = cyc + 2;
                        e.data = shadow[cfg_addr];
                        cfg_q.push_back(e);
                    end
                end else begin
                    pick = pick_burst(m_owner, m_run, ld_req, st_req);
                    if (pick == 0) begin
                        eg      = 3'b000;
                        m_owner = 0;
                        m_run   = 0;
                    end else begin
                        if (pick == m_owner) m_run = (m_run < MAX_BURST) ? m_run + 1 : MAX_BURST;
                        else m_run = 1;
                        m_owner = pick;
                        if (pick == 1) begin
                            eg       = 3'b010;
                            exp_addr = ld_addr;
                            e.due    = cyc + 2;
                            e.data   = shadow[ld_addr];
                            ld_q.push_back(e);
                        end else begin
                            eg        = 3'b001;
                            exp_we    = 1'b1;
                            exp_addr  = st_addr;
                            exp_wdata = st_wdata;
                        end
                    end
                end
                check("gnt_cfg_ld_st", 32'({cfg_gnt, ld_gnt, st_gnt}), 32'(eg));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic all_idle();
        cfg_req = 1'b0;
        ld_req  = 1'b0;
        st_req  = 1'b0;
    endtask

    // Stimulus
    initial begin : driver
        for (int i = 0; i < 65536; i++) begin
            bram[i]   = 8'(i + 16);
            shadow[i] = 8'(i + 16);
        end

        // All requests high through reset, then the first cycle after release
        #1 rst = 1'b0;
        cfg_req = 1'b1; cfg_we = 1'b0; cfg_addr = 16'h0003;
        ld_req  = 1'b1; ld_addr = 16'h0007;
        st_req  = 1'b1; st_addr = 16'h2000; st_wdata = 8'h55;
        repeat (3) step();
        rst = 1'b1;
        repeat (2) step();
        all_idle();
        repeat (4) step();

        // ld alone, addresses 0..5 back to back
        for (int i = 0; i < 6; i++) begin
            ld_req  = 1'b1;
            ld_addr = 16'(i);
            step();
        end
        all_idle();
        repeat (4) step();

        // ld and st both held high: alternating bursts of MAX_BURST
        for (int i = 0; i < 20; i++) begin
            ld_req   = 1'b1;
            ld_addr  = 16'(100 + i);
            st_req   = 1'b1;
            st_addr  = 16'(16'h1000 + i);
            st_wdata = 8'($urandom);
            step();
        end
        all_idle();
        repeat (4) step();

        // cfg pulse in the middle of an ld burst
        for (int i = 0; i < 12; i++) begin
            ld_req   = 1'b1;
            ld_addr  = 16'(200 + i);
            st_req   = 1'b1;
            st_addr  = 16'(16'h1100 + i);
            st_wdata = 8'($urandom);
            cfg_req  = (i == 2);
            cfg_we   = 1'b0;
            cfg_addr = 16'h0005;
            step();
        end
        all_idle();
        repeat (4) step();

        // cfg write followed by a cfg read of the same address
        cfg_req = 1'b1; cfg_we = 1'b1; cfg_addr = 16'h0040; cfg_wdata = 8'hAB;
        step();
        cfg_we = 1'b0;
        step();
        all_idle();
        repeat (4) step();

        // Reset one cycle after an ld read grant drops that read
        ld_req = 1'b1; ld_addr = 16'h0003;
        step();
        ld_req = 1'b0;
        rst    = 1'b0;
        step();
        rst = 1'b1;
        repeat (5) step();

        // Randomized traffic over a small address window, with occasional resets
        for (int i = 0; i < 800; i++) begin
            cfg_req   = ($urandom_range(0, 5) == 0);
            cfg_we    = 1'($urandom_range(0, 1));
            cfg_addr  = 16'($urandom_range(0, 31));
            cfg_wdata = 8'($urandom);
            ld_req    = ($urandom_range(0, 3) != 0);
            ld_addr   = 16'($urandom_range(0, 31));
            st_req    = ($urandom_range(0, 2) != 0);
            st_addr   = 16'($urandom_range(0, 31));
            st_wdata  = 8'($urandom);
            rst       = ($urandom_range(0, 199) != 0);
            step();
        end

        // Drain outstanding reads
        all_idle();
        rst = 1'b1;
        repeat (6) step();
        check("drain_cfg_queue", 32'(cfg_q.size()), 32'd0);
        check("drain_ld_queue", 32'(ld_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
